// File: rtl/cdb_arbiter_pkg.sv
// Shared types and helpers for the common data bus arbiter.
// The source encoding is what appears on cdb_src.
package cdb_arbiter_pkg;

    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LS  = 1'b1
    } cdb_src_e;

    // Round-robin pick between two pending heads; the caller qualifies with "any pending".
    function automatic cdb_src_e rr_pick(input logic alu_pending, input logic ls_pending,
                                         input cdb_src_e last_grant);
        cdb_src_e pick;
        pick = CDB_SRC_ALU;
        if (alu_pending && ls_pending) begin
            pick = (last_grant == CDB_SRC_LS) ? CDB_SRC_ALU : CDB_SRC_LS;
        end else if (ls_pending) begin
            pick = CDB_SRC_LS;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small per-source result FIFO with an extra pointer wrap bit to tell full from empty.
// The head is read combinationally so a pop can be broadcast on the same edge.
module cdb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign do_push = en && !clr && push && !full;
    assign do_pop  = en && !clr && pop && !empty;
    assign dout    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (en) begin
            if (clr) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers arithmetic and load/store results per source and
// broadcasts one registered entry per cycle, alternating sources under contention.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ROB_ID_W = 5,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                flush,
    input  logic                alu_valid,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [DATA_W-1:0]   alu_result,
    output logic                alu_ready,
    input  logic                ls_valid,
    input  logic [ROB_ID_W-1:0] ls_rob_id,
    input  logic [DATA_W-1:0]   ls_result,
    output logic                ls_ready,
    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [DATA_W-1:0]   cdb_result,
    output logic                cdb_src
);
    localparam int ENTRY_W = ROB_ID_W + DATA_W;

    // Index 0 is the arithmetic source, index 1 the load/store source.
    logic [1:0]         fifo_push;
    logic [1:0]         fifo_pop;
    logic [1:0]         fifo_empty;
    logic [1:0]         fifo_full;
    logic [ENTRY_W-1:0] fifo_din  [2];
    logic [ENTRY_W-1:0] fifo_dout [2];

    logic               grant_valid;
    cdb_src_e           grant_src;
    logic [ENTRY_W-1:0] grant_entry;

    logic                cdb_valid_reg;
    logic [ROB_ID_W-1:0] cdb_rob_id_reg;
    logic [DATA_W-1:0]   cdb_result_reg;
    cdb_src_e            cdb_src_reg;
    cdb_src_e            last_grant_reg;

    assign fifo_din[0] = {alu_rob_id, alu_result};
    assign fifo_din[1] = {ls_rob_id, ls_result};

    // Credit comes from registered occupancy only; a same-cycle pop frees nothing.
    assign alu_ready    = rdy && !fifo_full[0];
    assign ls_ready     = rdy && !fifo_full[1];
    assign fifo_push[0] = alu_valid && alu_ready;
    assign fifo_push[1] = ls_valid && ls_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            cdb_fifo #(
                .DEPTH(DEPTH),
                .WIDTH(ENTRY_W)
            ) u_fifo (
                .clk  (clk),
                .rst_n(rst_n),
                .en   (rdy),
                .clr  (flush),
                .push (fifo_push[gi]),
                .pop  (fifo_pop[gi]),
                .din  (fifo_din[gi]),
                .dout (fifo_dout[gi]),
                .empty(fifo_empty[gi]),
                .full (fifo_full[gi])
            );
        end
    endgenerate

    always_comb begin
        grant_valid = !fifo_empty[0] || !fifo_empty[1];
        grant_src   = rr_pick(!fifo_empty[0], !fifo_empty[1], last_grant_reg);
        grant_entry = (grant_src == CDB_SRC_LS) ? fifo_dout[1] : fifo_dout[0];
        fifo_pop    = '0;
        if (rdy && !flush && grant_valid) begin
            if (grant_src == CDB_SRC_LS) fifo_pop[1] = 1'b1;
            else                         fifo_pop[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_reg  <= 1'b0;
            cdb_rob_id_reg <= '0;
            cdb_result_reg <= '0;
            cdb_src_reg    <= CDB_SRC_ALU;
            last_grant_reg <= CDB_SRC_LS;
        end else if (rdy) begin
            if (flush) begin
                cdb_valid_reg  <= 1'b0;
                last_grant_reg <= CDB_SRC_LS;
            end else if (grant_valid) begin
                cdb_valid_reg  <= 1'b1;
                cdb_rob_id_reg <= grant_entry[ENTRY_W-1:DATA_W];
                cdb_result_reg <= grant_entry[DATA_W-1:0];
                cdb_src_reg    <= grant_src;
                last_grant_reg <= grant_src;
            end else begin
                cdb_valid_reg <= 1'b0;
            end
        end
    end

    assign cdb_valid  = cdb_valid_reg;
    assign cdb_rob_id = cdb_rob_id_reg;
    assign cdb_result = cdb_result_reg;
    assign cdb_src    = cdb_src_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, holding-producer streams and a random
// phase, all checked against a queue-based reference model of the bus.
module tb_cdb_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rdy = 1'b1, flush = 1'b0;
    logic        alu_valid = 1'b0, ls_valid = 1'b0;
    logic [4:0]  alu_rob_id = '0, ls_rob_id = '0;
    logic [31:0] alu_result = '0, ls_result = '0;
    logic        alu_ready, ls_ready;
    logic        cdb_valid, cdb_src;
    logic [4:0]  cdb_rob_id;
    logic [31:0] cdb_result;

    cdb_arbiter #(.DEPTH(DEPTH), .ROB_ID_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_result(alu_result), .alu_ready(alu_ready),
        .ls_valid(ls_valid), .ls_rob_id(ls_rob_id), .ls_result(ls_result), .ls_ready(ls_ready),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  id;
        logic [31:0] res;
    } ent_t;

    typedef struct {
        bit          av;
        logic [4:0]  aid;
        logic [31:0] ar;
        bit          lv;
        logic [4:0]  lid;
        logic [31:0] lr;
        bit          ev;
        logic [4:0]  eid;
        logic [31:0] eres;
        bit          esrc;
    } vec_t;

    ent_t        qa[$], ql[$];
    logic        m_valid, m_src, m_last;
    logic [4:0]  m_id;
    logic [31:0] m_res;
    int          total = 0, bad = 0;
    logic [5:0]  bc[$];
    logic [4:0]  a_next, l_next;
    logic        seen_ls_ready;
    bit          ls_block;
    vec_t        tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        qa.delete();
        ql.delete();
        m_valid = 1'b0; m_id = '0; m_res = '0; m_src = 1'b0; m_last = 1'b1;
    endfunction

    // One active edge of the bus, computed from the rules on plain queues.
    function automatic void model_edge();
        bit   acc_a, acc_l, have, pick;
        ent_t e;
        if (!rdy) return;
        if (flush) begin
            qa.delete();
            ql.delete();
            m_valid = 1'b0;
            m_last  = 1'b1;
            return;
        end
        acc_a = alu_valid && (qa.size() < DEPTH);
        acc_l = ls_valid && (ql.size() < DEPTH);
        have  = (qa.size() > 0) || (ql.size() > 0);
        if (qa.size() > 0 && ql.size() > 0) pick = !m_last;
        else                                pick = (ql.size() > 0);
        if (have) begin
            e = pick ? ql.pop_front() : qa.pop_front();
            m_valid = 1'b1; m_id = e.id; m_res = e.res; m_src = pick; m_last = pick;
        end else begin
            m_valid = 1'b0;
        end
        if (acc_a) qa.push_back('{alu_rob_id, alu_result});
        if (acc_l) ql.push_back('{ls_rob_id, ls_result});
    endfunction

    task automatic cycle(input bit r, input bit f, input bit av, input logic [4:0] aid,
                         input logic [31:0] ar, input bit lv, input logic [4:0] lid,
                         input logic [31:0] lr);
        rdy = r; flush = f;
        alu_valid = av; alu_rob_id = aid; alu_result = ar;
        ls_valid = lv; ls_rob_id = lid; ls_result = lr;
        #1;
        seen_ls_ready = ls_ready;
        chk("alu_ready", alu_ready, r && (qa.size() < DEPTH));
        chk("ls_ready", ls_ready, r && (ql.size() < DEPTH));
        model_edge();
        @(posedge clk);
        #1;
        chk("cdb_valid", cdb_valid, m_valid);
        chk("cdb_rob_id", cdb_rob_id, m_id);
        chk("cdb_result", cdb_result, m_res);
        chk("cdb_src", cdb_src, m_src);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Asserted and released between clock edges so the asynchronous path is exercised.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", cdb_valid, 0);
        chk("rst_id", cdb_rob_id, 0);
        chk("rst_result", cdb_result, 0);
        chk("rst_src", cdb_src, 0);
        chk("rst_alu_ready", alu_ready, rdy);
        chk("rst_ls_ready", ls_ready, rdy);
        rst_n = 1'b1;
        #1;
    endtask

    // Producers that hold an offer until it is accepted; records each active broadcast.
    task automatic stream(input int n, input int offer_cycles, input int freeze_at);
        bit r, off, acc_a, acc_l;
        for (int k = 0; k < n; k++) begin
            r     = !(k >= freeze_at && k < freeze_at + 3);
            off   = (k < offer_cycles);
            acc_a = r && off && (qa.size() < DEPTH);
            acc_l = r && off && (ql.size() < DEPTH);
            cycle(r, 1'b0, off, a_next, {27'd0, a_next} + 32'h100,
                  off, l_next, {27'd0, l_next} + 32'h200);
            if (off && !seen_ls_ready) ls_block = 1'b1;
            if (r && cdb_valid) bc.push_back({cdb_src, cdb_rob_id});
            if (acc_a) a_next++;
            if (acc_l) l_next++;
        end
    endtask

    task automatic check_order(input string name, input logic [4:0] a0, input logic [4:0] l0);
        logic [4:0] ea, el;
        ea = a0; el = l0;
        foreach (bc[i]) begin
            if (bc[i][5]) begin
                chk({name, "_ls_order"}, bc[i][4:0], el);
                el++;
            end else begin
                chk({name, "_alu_order"}, bc[i][4:0], ea);
                ea++;
            end
        end
        chk({name, "_alu_all"}, ea, a_next);
        chk({name, "_ls_all"}, el, l_next);
    endtask

    initial begin
        int cnt;
        // Fresh reset: last grant is LS, so a simultaneous pair goes ALU first.
        tbl[0] = '{1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 5'd0, 32'h0,  0};
        tbl[1] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1, 5'd1, 32'h11, 0};
        tbl[2] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1, 5'd2, 32'h22, 1};
        tbl[3] = '{1, 5'd3, 32'hAA, 0, 5'd0, 32'h0,  0, 5'd2, 32'h22, 1};
        tbl[4] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1, 5'd3, 32'hAA, 0};
        tbl[5] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 5'd3, 32'hAA, 0};

        #1;
        do_reset();
        foreach (tbl[i]) begin
            cycle(1'b1, 1'b0, tbl[i].av, tbl[i].aid, tbl[i].ar, tbl[i].lv, tbl[i].lid, tbl[i].lr);
            chk($sformatf("vec%0d_valid", i), cdb_valid, tbl[i].ev);
            chk($sformatf("vec%0d_id", i), cdb_rob_id, tbl[i].eid);
            chk($sformatf("vec%0d_result", i), cdb_result, tbl[i].eres);
            chk($sformatf("vec%0d_src", i), cdb_src, tbl[i].esrc);
        end

        // Contention: strict alternation, per-source order, and LS back-pressure.
        do_reset();
        a_next = 5'd0; l_next = 5'd16; bc.delete(); ls_block = 1'b0;
        stream(24, 10, 1000);
        chk("contention_count", bc.size() >= 8, 1);
        for (int i = 1; i < 8 && i < bc.size(); i++) chk($sformatf("alternate%0d", i), bc[i][5], !bc[i-1][5]);
        chk("first_src_alu", bc.size() > 0 && bc[0][5] == 1'b0, 1);
        chk("ls_backpressure", ls_block, 1);
        check_order("contention", 5'd0, 5'd16);

        // Flush with a same-cycle offer: nothing is broadcast afterwards.
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, 5'(k + 4), 32'h300 + k, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 5'h1E, 32'hDEAD, 1'b1, 5'h1D, 32'hBEEF);
        chk("flush_valid", cdb_valid, 0);
        chk("flush_alu_ready", alu_ready, 1);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            idle();
            if (cdb_valid) cnt++;
        end
        chk("flush_no_bcast", cnt, 0);

        // rdy low for three cycles mid-stream: nothing lost or duplicated.
        do_reset();
        a_next = 5'd8; l_next = 5'd20; bc.delete(); ls_block = 1'b0;
        stream(24, 12, 5);
        check_order("freeze", 5'd8, 5'd20);

        // Random traffic with occasional freezes, flushes and one asynchronous reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #2;
                do_reset();
            end
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 9) < 7, 5'($urandom), $urandom,
                  $urandom_range(0, 9) < 7, 5'($urandom), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
